writeback_control: RTL and testbench
====================================

WRITEBACK_CONTROL -- requirements
Module: writeback_control

Interface
REQ-001 SHALL have port: clock  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port: instruction  input  20  issued instruction (opcode [19:16], destination [15:12]).
REQ-004 SHALL have port: issueValid  input  1  instruction is presented for issue this cycle.
REQ-005 SHALL have port: ReadAddressRF1  input  4  first register-file read address driven by decode.
REQ-006 SHALL have port: ReadAddressRF2  input  4  second register-file read address driven by decode.
REQ-007 SHALL have port: aluResult  input  16  result for the entry currently in EX.
REQ-008 SHALL have port: memData  input  16  load data for the entry currently in MEM.
REQ-009 SHALL have port: WriteAddressRF  output  4  register-file write address.
REQ-010 SHALL have port: WriteDataRF  output  16  register-file write data.
REQ-011 SHALL have port: WriteEnableRF  output  1  register-file write strobe.
REQ-012 SHALL have port: stall  output  1  read-after-write hazard; decode holds, issue refused.

Function
REQ-013 SHALL hold three stage registers EX, MEM, WB; each holds valid, writes, isLoad, dest[3:0], data[15:0].
REQ-014 SHALL classify opcodes: 0000 NOP (no write); 1100 STORE (no write); 1011 LOAD (write memData); all others write aluResult; R0 writes permitted.
REQ-015 SHALL load EX on each edge with issueValid & ~stall; otherwise EX becomes a bubble (valid=0).
REQ-016 SHALL advance EX->MEM->WB every cycle unconditionally; MEM.data captures aluResult.
REQ-017 SHALL replace data with memData on MEM->WB transfer when isLoad=1.
REQ-018 SHALL drive WriteEnableRF = WB.valid & WB.writes, WriteAddressRF = WB.dest, WriteDataRF = WB.data, all combinational from WB.
REQ-019 SHALL yield issue-to-write latency of exactly 3 cycles: issued at edge N, WriteEnableRF high during cycle N+3.
REQ-020 SHALL assert stall combinationally when ReadAddressRF1 or ReadAddressRF2 equals dest of any stage with valid & writes (EX, MEM, WB).
REQ-021 SHALL evaluate stall regardless of issueValid; stall with issueValid=0 has no effect on state.
REQ-022 SHALL raise stall for both matches simultaneously as a single assertion; no priority among stages.
REQ-023 SHALL treat back-to-back writes to the same dest as independent entries, each written in order.
REQ-024 SHALL free the stall automatically once the last matching entry leaves WB (maximum 3 stall cycles).

Reset
REQ-025 SHALL on reset clear valid in all stages; dest and data to 0.
REQ-026 SHALL therefore present WriteEnableRF=0, WriteAddressRF=0, WriteDataRF=0 and stall=0 (no valid entries) during and after reset.
REQ-027 SHALL discard in-flight entries on reset mid-operation; no write occurs for them.

Configuration
REQ-028 SHALL honour macro WRITEBACK_BYPASS_EN: when defined, WB-stage matches are excluded from stall (register file is write-first); when undefined, EX, MEM and WB all participate (REQ-020).

Verification
REQ-029 SHALL cover: issue ADD (opcode 0001, dest 3), aluResult=0x00A5 in EX -> three cycles later WriteEnableRF=1, WriteAddressRF=3, WriteDataRF=0x00A5 for one cycle.
REQ-030 SHALL cover: issue LOAD (1011, dest 5), memData=0x1234 in MEM -> WriteDataRF=0x1234 at address 5 in cycle N+3.
REQ-031 SHALL cover: issue STORE (1100) and NOP -> WriteEnableRF stays 0 throughout.
REQ-032 SHALL cover: issue ADD dest 7, then ReadAddressRF1=7 -> stall=1 for 3 cycles (2 with WRITEBACK_BYPASS_EN), no EX load while stalled.
REQ-033 SHALL cover: reset asserted while two writes are in EX/MEM -> outputs zero immediately, no subsequent writes after release.

Source files
------------

// File: rtl/writeback_control_if.sv
// writeback_control_if: issue, read-address and register-file write bundle for writeback_control
interface writeback_control_if;
    logic [19:0] instruction;
    logic        issueValid;
    logic [3:0]  ReadAddressRF1;
    logic [3:0]  ReadAddressRF2;
    logic [15:0] aluResult;
    logic [15:0] memData;
    logic [3:0]  WriteAddressRF;
    logic [15:0] WriteDataRF;
    logic        WriteEnableRF;
    logic        stall;

    modport master (
        output instruction, issueValid, ReadAddressRF1, ReadAddressRF2, aluResult, memData,
        input  WriteAddressRF, WriteDataRF, WriteEnableRF, stall
    );

    modport slave (
        input  instruction, issueValid, ReadAddressRF1, ReadAddressRF2, aluResult, memData,
        output WriteAddressRF, WriteDataRF, WriteEnableRF, stall
    );
endinterface

// File: rtl/writeback_control.sv
// writeback_control: EX/MEM/WB destination tracking, register-file write-back and RAW stall; WRITEBACK_BYPASS_EN drops WB from the hazard check
module writeback_control (
    input  logic clock,
    input  logic reset,
    writeback_control_if.slave bus
);
    typedef struct packed {
        logic        valid;
        logic        writes;
        logic        is_load;
        logic [3:0]  dest;
        logic [15:0] data;
    } stage_t;

    stage_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [3:0] opcode;
    logic ex_hit, mem_hit, wb_hit, hazard;

    function automatic logic hit(input stage_t s, input logic [3:0] ra1, input logic [3:0] ra2);
        return s.valid && s.writes && (s.dest == ra1 || s.dest == ra2);
    endfunction

    assign opcode  = bus.instruction[19:16];
    assign ex_hit  = hit(ex_q, bus.ReadAddressRF1, bus.ReadAddressRF2);
    assign mem_hit = hit(mem_q, bus.ReadAddressRF1, bus.ReadAddressRF2);
`ifdef WRITEBACK_BYPASS_EN
    assign wb_hit  = 1'b0;
`else
    assign wb_hit  = hit(wb_q, bus.ReadAddressRF1, bus.ReadAddressRF2);
`endif
    assign hazard  = ex_hit | mem_hit | wb_hit;

    // Next stage contents: issue into EX unless stalled, MEM takes the ALU result, loads swap in memory data on entry to WB
    always_comb begin
        ex_d = '0;
        if (bus.issueValid && !hazard) begin
            ex_d.valid   = 1'b1;
            ex_d.writes  = opcode != 4'h0 && opcode != 4'hC;
            ex_d.is_load = opcode == 4'hB;
            ex_d.dest    = bus.instruction[15:12];
        end
        mem_d      = ex_q;
        mem_d.data = ex_q.valid ? bus.aluResult : 16'h0;
        wb_d       = mem_q;
        wb_d.data  = (mem_q.valid && mem_q.is_load) ? bus.memData : mem_q.data;
    end

    // Pipeline registers; reset discards every in-flight entry at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign bus.WriteEnableRF  = wb_q.valid & wb_q.writes;
    assign bus.WriteAddressRF = wb_q.dest;
    assign bus.WriteDataRF    = wb_q.data;
    assign bus.stall          = hazard;
endmodule

// File: tb/tb_writeback_control.sv
// tb_writeback_control: directed vectors for writeback_control with hand-computed expectations
module tb_writeback_control;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int n_total = 0;
    int n_pass = 0;
`ifdef WRITEBACK_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    writeback_control_if bus ();

    writeback_control dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] dst);
        bus.instruction = {op, dst, 12'h000};
        bus.issueValid  = 1'b1;
    endtask

    task automatic expect_wb(input string tag, input logic we, input logic [3:0] wa, input logic [15:0] wd);
        check({tag, "_we"}, 32'(bus.WriteEnableRF), 32'(we));
        if (we) begin
            check({tag, "_wa"}, 32'(bus.WriteAddressRF), 32'(wa));
            check({tag, "_wd"}, 32'(bus.WriteDataRF), 32'(wd));
        end
    endtask

    initial begin
        bus.instruction    = '0;
        bus.issueValid     = 1'b0;
        bus.ReadAddressRF1 = '0;
        bus.ReadAddressRF2 = '0;
        bus.aluResult      = '0;
        bus.memData        = '0;
        tick();
        check("rst_we", 32'(bus.WriteEnableRF), 0);
        check("rst_wa", 32'(bus.WriteAddressRF), 0);
        check("rst_wd", 32'(bus.WriteDataRF), 0);
        check("rst_stall", 32'(bus.stall), 0);
        tick();
        reset = 1'b0;
        tick();
        check("idle_wd", 32'(bus.WriteDataRF), 0);

        // ADD r3: written with the EX-cycle ALU result in cycle N+3
        issue(4'h1, 4'h3);
        tick();
        bus.issueValid = 1'b0;
        bus.aluResult  = 16'h00A5;
        expect_wb("add_c1", 1'b0, 4'h0, 16'h0);
        tick();
        bus.aluResult = 16'h0;
        expect_wb("add_c2", 1'b0, 4'h0, 16'h0);
        tick();
        expect_wb("add_c3", 1'b1, 4'h3, 16'h00A5);
        tick();
        expect_wb("add_c4", 1'b0, 4'h0, 16'h0);

        // LOAD r5: ALU result ignored, MEM-cycle memory data written
        issue(4'hB, 4'h5);
        tick();
        bus.issueValid = 1'b0;
        bus.aluResult  = 16'h7777;
        tick();
        bus.aluResult = 16'h0;
        bus.memData   = 16'h1234;
        expect_wb("ld_c2", 1'b0, 4'h0, 16'h0);
        tick();
        bus.memData = 16'h0;
        expect_wb("ld_c3", 1'b1, 4'h5, 16'h1234);
        tick();
        expect_wb("ld_c4", 1'b0, 4'h0, 16'h0);

        // STORE and NOP never write and never cause a hazard
        issue(4'hC, 4'h6);
        tick();
        issue(4'h0, 4'h8);
        bus.ReadAddressRF1 = 4'h6;
        #1 check("st_nostall", 32'(bus.stall), 0);
        tick();
        bus.issueValid = 1'b0;
        bus.ReadAddressRF1 = 4'h8;
        #1 check("nop_nostall", 32'(bus.stall), 0);
        bus.ReadAddressRF1 = 4'h0;
        for (int i = 0; i < 4; i++) begin
            check("stnop_we", 32'(bus.WriteEnableRF), 0);
            tick();
        end

        // RAW hazard on r7; the dependent ADD r9 must wait in decode
        issue(4'h1, 4'h7);
        tick();
        issue(4'h1, 4'h9);
        bus.ReadAddressRF1 = 4'h7;
        bus.aluResult      = 16'h0077;
        #1 check("raw_c1_stall", 32'(bus.stall), 1);
        tick();
        bus.aluResult = 16'h0;
        check("raw_c2_stall", 32'(bus.stall), 1);
        expect_wb("raw_c2", 1'b0, 4'h0, 16'h0);
        tick();
        check("raw_c3_stall", 32'(bus.stall), BYPASS ? 0 : 1);
        expect_wb("raw_c3", 1'b1, 4'h7, 16'h0077);
        tick();
        if (BYPASS) bus.issueValid = 1'b0;
        bus.aluResult = 16'h0099;
        check("raw_c4_stall", 32'(bus.stall), 0);
        for (int c = 5; c <= 8; c++) begin
            tick();
            bus.issueValid = 1'b0;
            if (c == 6) bus.aluResult = 16'h0;
            expect_wb($sformatf("raw9_c%0d", c), c == (BYPASS ? 6 : 7), 4'h9, 16'h0099);
        end
        bus.ReadAddressRF1 = 4'h0;

        // Back-to-back writes to rA stay independent; both read ports raise one stall
        issue(4'h2, 4'hA);
        tick();
        bus.aluResult = 16'h0011;
        tick();
        bus.issueValid = 1'b0;
        bus.aluResult  = 16'h0022;
        bus.ReadAddressRF1 = 4'hA;
        bus.ReadAddressRF2 = 4'hA;
        #1 check("dual_both", 32'(bus.stall), 1);
        bus.ReadAddressRF1 = 4'h0;
        #1 check("dual_rf2", 32'(bus.stall), 1);
        bus.ReadAddressRF2 = 4'h0;
        #1 check("dual_none", 32'(bus.stall), 0);
        tick();
        bus.aluResult = 16'h0;
        expect_wb("b2b_first", 1'b1, 4'hA, 16'h0011);
        tick();
        expect_wb("b2b_second", 1'b1, 4'hA, 16'h0022);
        tick();
        expect_wb("b2b_after", 1'b0, 4'h0, 16'h0);

        // Reset with writes to rB and rC in flight clears everything at once
        issue(4'h1, 4'hB);
        tick();
        bus.aluResult = 16'h00BB;
        issue(4'h1, 4'hC);
        tick();
        bus.issueValid = 1'b0;
        bus.aluResult  = 16'h00CC;
        bus.ReadAddressRF1 = 4'hB;
        #1 check("pre_rst_stall", 32'(bus.stall), 1);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_we", 32'(bus.WriteEnableRF), 0);
        check("mid_rst_wa", 32'(bus.WriteAddressRF), 0);
        check("mid_rst_wd", 32'(bus.WriteDataRF), 0);
        check("mid_rst_stall", 32'(bus.stall), 0);
        tick();
        reset = 1'b0;
        bus.aluResult = 16'h0;
        bus.ReadAddressRF1 = 4'h0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_we", 32'(bus.WriteEnableRF), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
